// File: rtl/risc_mem_pkg.sv
// risc_mem_pkg: shared state encoding, access sizes and byte-lane helpers for the core memory controllers
package risc_mem_pkg;
  typedef enum logic [1:0] {IDLE, LOAD_WAIT, RMW_READ, RMW_WRITE} state_t;
  localparam logic SIZE_BYTE = 1'b0;
  localparam logic SIZE_WORD = 1'b1;
  function automatic logic [31:0] lane_extract(input logic [31:0] w, input logic [1:0] lane, input logic sgn);
    logic [7:0] b;
    b = w[{lane, 3'b000} +: 8];
    return {{24{sgn & b[7]}}, b};
  endfunction
  function automatic logic [31:0] lane_merge(input logic [31:0] w, input logic [1:0] lane, input logic [7:0] b);
    logic [31:0] m;
    m = w;
    m[{lane, 3'b000} +: 8] = b;
    return m;
  endfunction
endpackage

// File: rtl/byte_lane_unit.sv
// byte_lane_unit: combinational byte-lane extract/extend and merge for 32-bit little-endian words
module byte_lane_unit
  import risc_mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic        sgn,
  input  logic [7:0]  wbyte,
  output logic [31:0] ext,
  output logic [31:0] merged
);
  assign ext    = lane_extract(word, lane, sgn);
  assign merged = lane_merge(word, lane, wbyte);
endmodule

// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl: byte/word load/store front end for the synchronous data RAM, byte stores by read-modify-write
module ram_access_ctrl
  import risc_mem_pkg::*;
#(
  parameter int addrWidth = 4,
  parameter int dataWidth = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic                 req_size,
  input  logic                 req_signed,
  input  logic [addrWidth+1:0] req_addr,
  input  logic [dataWidth-1:0] req_wdata,
  output logic                 resp_valid,
  output logic [dataWidth-1:0] resp_rdata,
  output logic                 resp_error,
  output logic [addrWidth-1:0] ram_read_address,
  output logic [addrWidth-1:0] ram_write_address,
  output logic                 ram_write,
  output logic [dataWidth-1:0] ram_in,
  input  logic [dataWidth-1:0] ram_out
);
  state_t state, state_n;
  logic [addrWidth-1:0] idx_q, req_idx;
  logic [1:0] lane_q;
  logic size_q, sgn_q, store_q, err_q, accept, misalign;
  logic [7:0] byte_q;
  logic [dataWidth-1:0] merge_q, lane_ext, lane_mrg;
  assign req_idx   = req_addr[addrWidth+1:2];
  assign misalign  = (req_size == SIZE_WORD) & (|req_addr[1:0]);
  assign req_ready = (state == IDLE) & ~reset;
  assign accept    = req_valid & req_ready;
  // Address is presented combinationally in IDLE so the RAM samples it on the accept edge.
  assign ram_read_address  = (state == IDLE) ? req_idx : idx_q;
  assign ram_write_address = (state == IDLE && req_write && req_size == SIZE_WORD) ? req_idx : idx_q;
  assign ram_write = ~reset & ((accept & req_write & (req_size == SIZE_WORD) & ~misalign) | (state == RMW_WRITE));
  assign ram_in    = (state == RMW_WRITE) ? merge_q : req_wdata;
  byte_lane_unit u_lane (
    .word  (ram_out),
    .lane  (lane_q),
    .sgn   (sgn_q),
    .wbyte (byte_q),
    .ext   (lane_ext),
    .merged(lane_mrg)
  );
  always_comb begin
    state_n = state;
    if (state == IDLE && accept) state_n = (req_write && req_size == SIZE_BYTE) ? RMW_READ : LOAD_WAIT;
    else if (state == RMW_READ) state_n = RMW_WRITE;
    else if (state != IDLE) state_n = IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      idx_q      <= '0;
      lane_q     <= '0;
      size_q     <= 1'b0;
      sgn_q      <= 1'b0;
      store_q    <= 1'b0;
      err_q      <= 1'b0;
      byte_q     <= '0;
      merge_q    <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_error <= 1'b0;
    end else begin
      state      <= state_n;
      resp_valid <= (state == LOAD_WAIT) | (state == RMW_WRITE);
      if (accept) begin
        idx_q   <= req_idx;
        lane_q  <= req_addr[1:0];
        size_q  <= req_size;
        sgn_q   <= req_signed;
        store_q <= req_write;
        err_q   <= misalign;
        byte_q  <= req_wdata[7:0];
      end
      if (state == RMW_READ) merge_q <= lane_mrg;
      if (state == LOAD_WAIT) begin
        resp_error <= err_q;
        resp_rdata <= (err_q | store_q) ? '0 : ((size_q == SIZE_WORD) ? ram_out : lane_ext);
      end
      if (state == RMW_WRITE) begin
        resp_error <= 1'b0;
        resp_rdata <= '0;
      end
    end
  end
endmodule

// File: doc/ram_access_ctrl.md
Name: ram_access_ctrl

Overview:
- Initiator-side controller for the team's synchronous single-port-read/single-port-write data RAM: 32-bit words, one-cycle registered read, word-only writes.
- Accepts byte/word load/store requests from the RISC core over a valid/ready handshake and drives the RAM address, write, data-in and data-out pins.
- Byte loads are lane-extracted and zero/sign-extended.
- Byte stores are done as read-modify-write, since the RAM has no byte enables.

Parameters:
- addrWidth, 4, RAM word-address width (RAM depth = 2**addrWidth words); core byte address is addrWidth+2 bits.
- dataWidth, 32, word width; fixed at 32 (4 little-endian byte lanes).

Ports:
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept; transfer on req_valid & req_ready at posedge.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  1  0 = byte, 1 = word.
- req_signed  in  1  byte load: 1 = sign-extend, 0 = zero-extend; ignored otherwise.
- req_addr  in  addrWidth+2  byte address.
- req_wdata  in  32  store data; byte store uses bits [7:0].
- resp_valid  out  1  one-cycle completion pulse for every accepted request; no backpressure.
- resp_rdata  out  32  load result; 0 for stores and errors.
- resp_error  out  1  misaligned word access.
- ram_read_address  out  addrWidth  to RAM readAddress.
- ram_write_address  out  addrWidth  to RAM writeAddress.
- ram_write  out  1  to RAM write.
- ram_in  out  32  to RAM in.
- ram_out  in  32  from RAM out (registered; valid one edge after address sampled).

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-high.
- Reset values: state=IDLE, resp_valid=0, resp_rdata=0, resp_error=0, latched request regs=0.
- While reset is high, req_ready=0 and ram_write=0 (combinational gating).
- Word index = addr[addrWidth+1:2]; lane = addr[1:0]; lane 0 = bits [7:0].
- States: IDLE, LOAD_WAIT, RMW_READ, RMW_WRITE.
- req_ready = (state==IDLE) & ~reset.
- RAM drive, IDLE: ram_read_address = word index of req_addr (combinational), so the RAM samples it on the accept edge.
- RAM drive, other states: ram_read_address = latched index.
- ram_write_address = latched index, except a word store in IDLE, where it comes directly from req_addr.
- Accept edge E0, word load, aligned: go to LOAD_WAIT. At E1, resp_rdata=ram_out, resp_valid=1, go to IDLE.
- Accept edge E0, byte load: same flow as word load. resp_rdata = selected lane, zero- or sign-extended.
- Accept edge E0, word store, aligned: ram_write=1 and ram_in=req_wdata combinationally during the accept cycle, so the RAM writes at E0. Go to LOAD_WAIT as an ack slot; at E1 resp_valid=1, resp_rdata=0.
- Accept edge E0, byte store: go to RMW_READ; latch lane and wdata[7:0].
  - RMW_READ: at E1 capture ram_out into the merge register with the latched lane replaced; go to RMW_WRITE.
  - RMW_WRITE: ram_write=1, ram_in=merge register; the RAM writes at E2. At E2 resp_valid=1, go to IDLE.
- Misaligned word access (req_size=1, addr[1:0]≠0): ram_write stays 0. At E1 resp_valid=1, resp_error=1, resp_rdata=0.
- Latency from accept edge to resp_valid: 1 cycle for loads, word stores and errors; 2 cycles for byte stores.
- Throughput: a new request can be accepted in the same cycle resp_valid is high (IDLE).
- resp_valid is exactly one cycle wide; resp_rdata and resp_error are held until the next response.
- ram_write is never asserted outside the cases above.
- Only one operation is in flight, so there is no RAM read/write same-address hazard.
- Reset mid-RMW: ram_write drops immediately, the write is lost, no response is issued; state=IDLE on release.
- Reset mid-load: the response is dropped.
- Address wrap: the index is truncated to addrWidth bits; top address 4*(2**addrWidth)-1 is legal with no wrap logic.

Decomposition:
- Shared package (risc_mem_pkg): state encoding; size constants SIZE_BYTE=0, SIZE_WORD=1; lane-extract/sign-extend and lane-merge functions.
- Optional sub-module: byte_lane_unit (combinational extract/extend and merge), reused by the future I/O port controller.
- The FSM stays in ram_access_ctrl.

Test Plan:
- Preload RAM word 3 = 0x8899AABB; word load addr 0x0C -> resp_rdata=0x8899AABB, resp_valid 1 cycle after accept, resp_error=0.
- Byte loads addr 0x0D: req_signed=1 -> 0xFFFFFFAA; req_signed=0 -> 0x000000AA.
- Byte store 0x55 to addr 0x0E, then word load 0x0C -> 0x8855AABB. Check ram_write is high only in RMW_WRITE and resp_valid comes 2 cycles after accept.
- Back-to-back: word store 0x12345678 to addr 0x3C, accepted in the cycle its predecessor's resp_valid is high; then load 0x3C -> 0x12345678. req_ready low during LOAD_WAIT.
- Misaligned word store to addr 0x06 -> resp_error=1, resp_rdata=0, word 1 unchanged, ram_write never asserted.
- Assert reset during RMW_READ of a byte store to 0x0C -> no RAM write, no resp_valid; all outputs at reset values; word 3 unchanged.
